// File: rtl/conv_dot_engine.sv
// ---------------------------------------------------------------------------
// conv_dot_engine
//
// Serial dot-product / sum-of-absolute-differences engine. Two packed
// vectors of N unsigned W-bit elements are captured on an accepted start.
// One element pair is then processed per clock. The accumulated result is
// published with a one-cycle done pulse. With N=6, W=1, mode=0 it computes
// the AND-popcount of the two bit vectors.
//
// Handshake: start is a request that is accepted only on an edge where
// busy=0 and clear=0. Requests while busy=1 are dropped, never queued.
// busy=1 for exactly N cycles after acceptance. done=1 for the single cycle
// after the last RUN edge. busy and done are never high together. A start
// presented in the done cycle is accepted, which gives back-to-back
// operation.
//
// Ports
//   clock       in   rising-edge clock
//   reset_n     in   asynchronous active-low reset
//   start       in   operation request (sampled while busy=0)
//   clear       in   synchronous abort; has priority over start
//   mode        in   0: sum a[i]*b[i], 1: sum |a[i]-b[i]| (captured with start)
//   a_in        in   vector A; element i at [i*W +: W]
//   b_in        in   vector B; same packing as a_in
//   busy        out  operation in progress (registered)
//   done        out  one-cycle pulse when result updates (registered)
//   result      out  last completed result; held until the next completion
//   o_dbg_state out  FSM state (0 = IDLE, 1 = RUN)
// ---------------------------------------------------------------------------
module conv_dot_engine #(
    parameter int N     = 6,
    parameter int W     = 2,
    parameter int OUT_W = 2*W + $clog2(N+1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             clear,
    input  logic             mode,
    input  logic [N*W-1:0]   a_in,
    input  logic [N*W-1:0]   b_in,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] result,
    output logic             o_dbg_state
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [N*W-1:0]   r_a;
    logic [N*W-1:0]   r_b;
    logic             r_mode;
    logic [OUT_W-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [OUT_W-1:0] r_result;

    logic [W-1:0]     w_a0;
    logic [W-1:0]     w_b0;
    logic [2*W-1:0]   w_prod;
    logic [W-1:0]     w_diff;
    logic [OUT_W-1:0] w_term;
    logic [OUT_W-1:0] w_sum;
    logic             w_last;

    // The low element of each shift register is the pair processed this edge.
    assign w_a0   = r_a[W-1:0];
    assign w_b0   = r_b[W-1:0];
    // Operands are widened first so the product is formed at full 2W width.
    assign w_prod = {{W{1'b0}}, w_a0} * {{W{1'b0}}, w_b0};
    assign w_diff = (w_a0 >= w_b0) ? (w_a0 - w_b0) : (w_b0 - w_a0);
    assign w_term = r_mode ? {{(OUT_W-W){1'b0}}, w_diff}
                           : {{(OUT_W-2*W){1'b0}}, w_prod};
    assign w_sum  = r_acc + w_term;
    assign w_last = (r_cnt == CW'(N-1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_mode   <= 1'b0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            if (clear) begin
                // Abort: result keeps its last completed value.
                r_state <= IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            r_a     <= a_in;
                            r_b     <= b_in;
                            r_mode  <= mode;
                            r_acc   <= '0;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= RUN;
                        end
                    end
                    RUN: begin
                        r_acc <= w_sum;
                        r_a   <= r_a >> W;
                        r_b   <= r_b >> W;
                        r_cnt <= r_cnt + CW'(1);
                        if (w_last) begin
                            // Publish acc + final term directly.
                            r_result <= w_sum;
                            r_done   <= 1'b1;
                            r_busy   <= 1'b0;
                            r_state  <= IDLE;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign result      = r_result;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_conv_dot_engine.sv
module tb_conv_dot_engine;

  localparam int N   = 6;
  localparam int W   = 2;
  localparam int OW  = 2*W + $clog2(N+1);
  localparam int LW  = 1;
  localparam int LOW = 2*LW + $clog2(N+1);

  // ---------------- clock / reset ----------------
  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  initial forever #5 clock = ~clock;

  // ---------------- main DUT (N=6, W=2) ----------------
  logic            start = 1'b0;
  logic            clear = 1'b0;
  logic            mode  = 1'b0;
  logic [N*W-1:0]  a_in  = '0;
  logic [N*W-1:0]  b_in  = '0;
  logic            busy;
  logic            done;
  logic [OW-1:0]   result;
  logic            dbg_state;

  conv_dot_engine #(.N(N), .W(W)) u_dut (
    .clock(clock), .reset_n(reset_n), .start(start), .clear(clear),
    .mode(mode), .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
    .result(result), .o_dbg_state(dbg_state)
  );

  // ---------------- legacy DUT (N=6, W=1) ----------------
  logic            l_start = 1'b0;
  logic            l_clear = 1'b0;
  logic            l_mode  = 1'b0;
  logic [N*LW-1:0] l_a     = '0;
  logic [N*LW-1:0] l_b     = '0;
  logic            l_busy;
  logic            l_done;
  logic [LOW-1:0]  l_result;
  logic            l_dbg_state;

  conv_dot_engine #(.N(N), .W(LW)) u_leg (
    .clock(clock), .reset_n(reset_n), .start(l_start), .clear(l_clear),
    .mode(l_mode), .a_in(l_a), .b_in(l_b), .busy(l_busy), .done(l_done),
    .result(l_result), .o_dbg_state(l_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] l_exp_q[$];
  logic [63:0] model_result   = '0;
  logic [63:0] l_model_result = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: element-wise arithmetic straight from the definition.
  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic m, input int n, input int w);
    logic [63:0] s;
    logic [63:0] mask;
    logic [63:0] ea;
    logic [63:0] eb;
    s    = '0;
    mask = (64'd1 << w) - 64'd1;
    for (int i = 0; i < n; i++) begin
      ea = (a >> (i*w)) & mask;
      eb = (b >> (i*w)) & mask;
      if (m) s = s + ((ea > eb) ? (ea - eb) : (eb - ea));
      else   s = s + ea * eb;
    end
    return s;
  endfunction

  function automatic logic [N*W-1:0] pack(input int e0, input int e1, input int e2,
                                          input int e3, input int e4, input int e5);
    int e[6];
    logic [N*W-1:0] v;
    e = '{e0, e1, e2, e3, e4, e5};
    v = '0;
    for (int i = 0; i < 6; i++) v[i*W +: W] = W'(e[i]);
    return v;
  endfunction

  // Compare processes: every cycle the held result must equal the last
  // expected completion, done must match a queued operation, and busy/done
  // must be exclusive.
  always @(negedge clock) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_done", 64'(done), 64'd0);
      else model_result = exp_q.pop_front();
    end
    check("result_vs_model", 64'(result), model_result);
    check("busy_done_excl", 64'(busy & done), 64'd0);
  end

  always @(negedge clock) begin
    if (l_done === 1'b1) begin
      if (l_exp_q.size() == 0) check("leg_unexpected_done", 64'(l_done), 64'd0);
      else l_model_result = l_exp_q.pop_front();
    end
    check("leg_result_vs_model", 64'(l_result), l_model_result);
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                       input logic m, input bit push);
    a_in  = a;
    b_in  = b;
    mode  = m;
    start = 1'b1;
    if (push) exp_q.push_back(model(64'(a), 64'(b), m, N, W));
  endtask

  task automatic wait_done(output int cyc, output int bc);
    cyc = 0;
    bc  = 0;
    do begin
      @(negedge clock);
      start = 1'b0;
      cyc++;
      if (busy) bc++;
    end while (done !== 1'b1 && cyc < 30);
    if (done !== 1'b1) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic l_issue(input logic [N*LW-1:0] a, input logic [N*LW-1:0] b);
    l_a     = a;
    l_b     = b;
    l_mode  = 1'b0;
    l_start = 1'b1;
    l_exp_q.push_back(model(64'(a), 64'(b), 1'b0, N, LW));
  endtask

  task automatic l_wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clock);
      l_start = 1'b0;
      cyc++;
    end while (l_done !== 1'b1 && cyc < 30);
    if (l_done !== 1'b1) check("leg_done_timeout", 64'd0, 64'd1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int bc;
    logic [N*W-1:0] ra;
    logic [N*W-1:0] rb;

    // Model pinned against hand-computed values.
    check("model_dot",  model(64'(pack(1,2,3,0,1,3)), 64'(pack(2,2,1,3,3,3)), 1'b0, N, W), 64'd21);
    check("model_sad",  model(64'(pack(3,0,2,1,0,3)), 64'(pack(0,3,2,0,1,1)), 1'b1, N, W), 64'd10);
    check("model_leg",  model(64'b101101, 64'b111001, 1'b0, N, LW), 64'd3);

    // Reset and idle.
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_busy",   64'(busy),   64'd0);
    check("reset_done",   64'(done),   64'd0);
    check("reset_result", 64'(result), 64'd0);
    reset_n = 1'b1;
    @(negedge clock);
    check("idle_busy",   64'(busy),   64'd0);
    check("idle_result", 64'(result), 64'd0);

    // Dot product.
    issue(pack(1,2,3,0,1,3), pack(2,2,1,3,3,3), 1'b0, 1'b1);
    wait_done(cyc, bc);
    check("dot_latency",  64'(cyc),    64'(N+1));
    check("dot_busy_len", 64'(bc),     64'(N));
    check("dot_result",   64'(result), 64'd21);

    // SAD.
    @(negedge clock);
    issue(pack(3,0,2,1,0,3), pack(0,3,2,0,1,1), 1'b1, 1'b1);
    wait_done(cyc, bc);
    check("sad_result", 64'(result), 64'd10);

    // Max-value dot product: no wrap.
    @(negedge clock);
    issue(pack(3,3,3,3,3,3), pack(3,3,3,3,3,3), 1'b0, 1'b1);
    wait_done(cyc, bc);
    check("max_result", 64'(result), 64'd54);

    // Back-to-back: start again in the done cycle.
    issue(pack(1,2,3,0,1,3), pack(2,2,1,3,3,3), 1'b0, 1'b1);
    wait_done(cyc, bc);
    check("b2b_first_result", 64'(result), 64'd21);
    issue(pack(3,0,2,1,0,3), pack(0,3,2,0,1,1), 1'b1, 1'b1);
    wait_done(cyc, bc);
    check("b2b_gap",           64'(cyc),    64'd7);
    check("b2b_second_result", 64'(result), 64'd10);

    // Start mid-RUN with different operands is ignored.
    @(negedge clock);
    issue(pack(1,2,3,0,1,3), pack(2,2,1,3,3,3), 1'b0, 1'b1);
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    a_in  = pack(3,3,3,3,3,3);
    b_in  = pack(0,0,0,0,0,0);
    mode  = 1'b1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(cyc, bc);
    check("ignored_start_latency", 64'(cyc),    64'd4);
    check("ignored_start_result",  64'(result), 64'd21);
    repeat (10) @(negedge clock);
    check("ignored_start_idle", 64'(busy), 64'd0);

    // Clear at RUN cycle 3: no done, result held.
    @(negedge clock);
    issue(pack(3,0,2,1,0,3), pack(0,3,2,0,1,1), 1'b1, 1'b0);
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("pre_clear_busy", 64'(busy), 64'd1);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    check("clear_busy", 64'(busy), 64'd0);
    check("clear_done", 64'(done), 64'd0);
    repeat (10) @(negedge clock);
    check("clear_result_held", 64'(result), 64'd21);

    // Clear and start together: stays IDLE.
    @(negedge clock);
    a_in  = pack(3,3,3,3,3,3);
    b_in  = pack(3,3,3,3,3,3);
    mode  = 1'b0;
    start = 1'b1;
    clear = 1'b1;
    @(negedge clock);
    start = 1'b0;
    clear = 1'b0;
    check("clr_start_busy", 64'(busy), 64'd0);
    repeat (8) @(negedge clock);
    check("clr_start_busy_late", 64'(busy),   64'd0);
    check("clr_start_result",    64'(result), 64'd21);

    // Asynchronous reset mid-RUN.
    @(negedge clock);
    issue(pack(3,3,3,3,3,3), pack(3,3,3,3,3,3), 1'b0, 1'b0);
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    model_result = '0;
    exp_q.delete();
    #1;
    check("async_rst_busy",   64'(busy),   64'd0);
    check("async_rst_done",   64'(done),   64'd0);
    check("async_rst_result", 64'(result), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
    check("async_rst_idle", 64'(busy), 64'd0);

    // Random operations on the main engine, both modes.
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      ra = (N*W)'($urandom);
      rb = (N*W)'($urandom);
      issue(ra, rb, 1'($urandom_range(0, 1)), 1'b1);
      wait_done(cyc, bc);
      check("rand_latency", 64'(cyc), 64'(N+1));
    end

    // Legacy equivalence: W=1 AND-popcount.
    @(negedge clock);
    l_issue(6'b101101, 6'b111001);
    l_wait_done(cyc);
    check("leg_result",  64'(l_result), 64'd3);
    check("leg_latency", 64'(cyc),      64'(N+1));
    for (int k = 0; k < 1000; k++) begin
      @(negedge clock);
      l_issue(6'($urandom), 6'($urandom));
      l_wait_done(cyc);
    end

    repeat (3) @(negedge clock);
    check("final_queue_empty",     64'(exp_q.size()),   64'd0);
    check("leg_final_queue_empty", 64'(l_exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
